// File: rtl/adc_freq_pkg.sv
// Shared definitions for the ADC sample-clock divider bank: rate index type,
// bank size and the switch-boundary mask helper.
package adc_freq_pkg;

    localparam int ADC_FREQ_NUM   = 8;
    localparam int ADC_FREQ_SEL_W = 3;

    typedef logic [ADC_FREQ_SEL_W-1:0] adc_rate_t;

    // Low (m+base_shift+1) bits set: the counter bits that must all be ones for
    // both the old and the new divided clock to fall together on the next edge.
    function automatic logic [31:0] adc_boundary_mask(input adc_rate_t m, input int base_shift);
        return (32'd1 << (int'(m) + base_shift + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/adc_sel_sync.sv
// Two-flop synchronizer for the rate-select index; synchronous active-low reset.
module adc_sel_sync
    import adc_freq_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_n_in,
    input  adc_rate_t d,
    output adc_rate_t q
);

    adc_rate_t stage1;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/adc_freq_div_gen.sv
// Power-of-two ADC sample-clock divider bank with glitch-free rate selection.
// Define ADC_FREQ_SEL_SYNC_EN to pass sel_in through a 2-flop synchronizer.
module adc_freq_div_gen
    import adc_freq_pkg::*;
#(
    parameter int BASE_SHIFT = 2,
    parameter int CNT_W      = 8 + BASE_SHIFT
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [ADC_FREQ_SEL_W-1:0] sel_in,
    output logic [ADC_FREQ_NUM-1:0] clk_div_out,
    output logic                    clk_sel_out,
    output logic                    sample_stb_out,
    output logic                    sel_busy_out
);

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    adc_rate_t               sel_src;
    adc_rate_t               sel_tgt;
    adc_rate_t               sel_act;
    adc_rate_t               sel_act_next;
    adc_rate_t               sel_max;
    logic [31:0]             cnt_ext;
    logic [31:0]             bnd_mask;
    logic                    busy;
    logic                    do_switch;
    logic [ADC_FREQ_NUM-1:0] div_next;
    logic                    clk_sel_next;

`ifdef ADC_FREQ_SEL_SYNC_EN
    adc_sel_sync u_sel_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d        (sel_in),
        .q        (sel_src)
    );
`else
    assign sel_src = sel_in;
`endif

    always_comb begin
        cnt_next  = cnt + 1'b1;
        busy      = (sel_tgt != sel_act);
        sel_max   = (sel_act > sel_tgt) ? sel_act : sel_tgt;
        bnd_mask  = adc_boundary_mask(sel_max, BASE_SHIFT);
        cnt_ext   = 32'(cnt);
        // Switch only where the slower of the two clocks falls, so neither
        // the outgoing nor the incoming clock is cut short.
        do_switch = busy && ((cnt_ext & bnd_mask) == bnd_mask);
        sel_act_next = do_switch ? sel_tgt : sel_act;

        div_next     = '0;
        clk_sel_next = 1'b0;
        for (int k = 0; k < ADC_FREQ_NUM; k++) begin
            div_next[k] = cnt_next[k+BASE_SHIFT];
            if (sel_act_next == ADC_FREQ_SEL_W'(k)) begin
                clk_sel_next = cnt_next[k+BASE_SHIFT];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt            <= '0;
            sel_tgt        <= '0;
            sel_act        <= '0;
            clk_div_out    <= '0;
            clk_sel_out    <= 1'b0;
            sample_stb_out <= 1'b0;
            sel_busy_out   <= 1'b0;
        end else begin
            cnt            <= cnt_next;
            sel_tgt        <= sel_src;
            sel_act        <= sel_act_next;
            clk_div_out    <= div_next;
            clk_sel_out    <= clk_sel_next;
            sample_stb_out <= clk_sel_next & ~clk_sel_out;
            // Registered image of (sel_tgt != sel_act) for the coming cycle.
            sel_busy_out   <= (sel_src != sel_act_next);
        end
    end

endmodule

// File: tb/tb_adc_freq_div_gen.sv
// Directed self-checking bench for adc_freq_div_gen: reset, switching,
// retargeting, mid-switch reset and the async-glitch-on-reset case.
module tb_adc_freq_div_gen;

`ifdef ADC_FREQ_SEL_SYNC_EN
    localparam int SEL_LAT = 3;
`else
    localparam int SEL_LAT = 1;
`endif

    logic       clk_in;
    logic       rst_n_in;
    logic [2:0] sel_in;
    logic [7:0] clk_div_out;
    logic       clk_sel_out;
    logic       sample_stb_out;
    logic       sel_busy_out;

    int checks    = 0;
    int failures  = 0;
    int tcnt      = 0;
    int exp_act   = 0;
    int exp_busy  = 0;

    adc_freq_div_gen dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .sel_in         (sel_in),
        .clk_div_out    (clk_div_out),
        .clk_sel_out    (clk_sel_out),
        .sample_stb_out (sample_stb_out),
        .sel_busy_out   (sel_busy_out)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (tcnt=%0d)", tag, got, exp, tcnt);
        end
    endtask

    // Expected outputs derived from the bench's own counter and rate index.
    task automatic check_cycle();
        logic [7:0] exp_div;
        int         exp_sel;
        int         exp_stb;
        for (int k = 0; k < 8; k++) exp_div[k] = ((tcnt >> (k + 2)) & 1) != 0;
        exp_sel = (tcnt >> (exp_act + 2)) & 1;
        exp_stb = ((tcnt % (1 << (exp_act + 3))) == (1 << (exp_act + 2))) ? 1 : 0;
        check_val("clk_div", 32'(clk_div_out), 32'(exp_div));
        check_val("clk_sel", 32'(clk_sel_out), 32'(exp_sel));
        check_val("sample_stb", 32'(sample_stb_out), 32'(exp_stb));
        check_val("sel_busy", 32'(sel_busy_out), 32'(exp_busy));
    endtask

    task automatic step();
        logic r;
        r = rst_n_in;
        @(posedge clk_in);
        #1;
        tcnt = r ? (tcnt + 1) % 1024 : 0;
        check_cycle();
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (tcnt != target && n < 2100) begin
            step();
            n++;
        end
        check_val("run_to_budget", 32'(tcnt), 32'(target));
    endtask

    // Drive a new index; busy changes once it has reached the target register.
    task automatic request(input int v, input int new_busy);
        sel_in = 3'(v);
        repeat (SEL_LAT - 1) step();
        exp_busy = new_busy;
    endtask

    task automatic check_pulse_widths(input int n_pulses, input int width);
        int n;
        int hi;
        for (int p = 0; p < n_pulses; p++) begin
            n = 0;
            while (clk_sel_out == 1'b1 && n < 100) begin step(); n++; end
            n = 0;
            while (clk_sel_out == 1'b0 && n < 100) begin step(); n++; end
            hi = 0;
            while (clk_sel_out == 1'b1 && hi < 100) begin step(); hi++; end
            check_val("sel_pulse_width", 32'(hi), 32'(width));
        end
    endtask

    initial begin
        rst_n_in = 1'b0;
        sel_in   = 3'd0;
        repeat (3) step();

        // Reset release at index 0; covers clk_div_out[7] rising at 512.
        rst_n_in = 1'b1;
        run_to(600);

        // Switch 0 -> 7 requested at cnt=5, applied at the 1023 -> 0 wrap.
        run_to(5);
        request(7, 1);
        run_to(1023);
        exp_act  = 7;
        exp_busy = 0;
        run_to(0);
        run_to(520);

        // Switch 7 -> 2 requested mid-period.
        run_to(300);
        request(2, 1);
        run_to(1023);
        exp_act  = 2;
        exp_busy = 0;
        run_to(0);
        check_pulse_widths(3, 16);
        run_to(100);

        // Back to 0 at the cnt[4:0] boundary.
        request(0, 1);
        run_to(127);
        exp_act  = 0;
        exp_busy = 0;
        run_to(128);

        // Retarget 0 -> 5 -> 3: 3 applied at cnt[5:0] all ones, 5 never active.
        run_to(130);
        request(5, 1);
        run_to(140);
        request(3, 1);
        run_to(191);
        exp_act  = 3;
        exp_busy = 0;
        run_to(400);

        // Request back to the active index before its boundary: no switch.
        request(4, 1);
        run_to(405);
        request(3, 0);
        run_to(600);

        // Async glitch on reset between edges, then real reset mid-switch.
        run_to(500);
        request(7, 1);
        run_to(510);
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
        run_to(520);
        rst_n_in = 1'b0;
        sel_in   = 3'd0;
        exp_act  = 0;
        exp_busy = 0;
        step();
        step();
        rst_n_in = 1'b1;
        run_to(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_freq_div_gen.md
# adc_freq_div_gen

Free-running divider bank that generates the eight power-of-two ADC sample-clock candidates and a glitch-free selected sample clock with a one-cycle sample strobe. It sits on the source side of the ADC rate-selection path, between the system clock and the ADC front-end and FIR input stage. Rate changes requested on `sel_in` are applied only at a common falling-edge boundary, so no runt pulse reaches the ADC.

## Interface
- `BASE_SHIFT`, default 2: bit `k` has divide ratio 2^(k+BASE_SHIFT+1). With the default, ratios run from /8 for bit 0 to /1024 for bit 7.
- `CNT_W`, default 8+BASE_SHIFT: counter width. Derived; do not override.
- `clk_in`  in  1: system clock. This is the only clock domain.
- `rst_n_in`  in  1: reset, synchronous, active-low.
- `sel_in`  in  3: requested rate index, 0 to 7.
- `clk_div_out`  out  8: all eight divided clocks, 50 % duty, registered.
- `clk_sel_out`  out  1: selected divided clock, registered, glitch-free.
- `sample_stb_out`  out  1: one-cycle pulse in the first cycle `clk_sel_out` is high.
- `sel_busy_out`  out  1: high while a requested rate is pending and not yet applied.

## Operation
- `cnt` is a `CNT_W`-bit up-counter. It increments every cycle and wraps from all-ones to 0.
- `clk_div_out[k]` = `cnt[k+BASE_SHIFT]`.
- `sel_tgt` is a register that captures `sel_in` every cycle (see Configuration). `sel_act` is the active index.
- `sel_busy_out` = (`sel_tgt` != `sel_act`).
- Switch condition: busy, and `cnt[m+BASE_SHIFT:0]` all ones, where m = max(`sel_act`, `sel_tgt`).
  - At that edge `sel_act` <= `sel_tgt`.
  - At that edge the old and new clock bits both fall to 0, so the switch produces no glitch.
- `clk_sel_out` <= bit (`sel_act_next`+BASE_SHIFT) of `cnt_next`. It is exactly aligned with `clk_div_out`.
- `sample_stb_out` <= `clk_sel_out_next` AND NOT `clk_sel_out`.
- If `sel_tgt` changes again while busy, the boundary is recomputed from the new target. The last value wins, and no intermediate index is ever applied.
- A request equal to `sel_act` clears busy and causes no switch.
- Reset values (next edge with `rst_n_in`=0, including mid-operation):
  - `cnt`=0, `sel_tgt`=0, `sel_act`=0.
  - All outputs 0.
  - Synchronizer stages, when present, also reset to 0.

## Timing
- The counter and all outputs update on the rising edge of `clk_in`. All outputs come directly from flops.
- `sel_in` to `sel_tgt` latency:
  - 1 cycle without the synchronizer.
  - 3 cycles with it.
- Switch latency is from `sel_tgt` change to `sel_act` update. It is at most 2^(m+BASE_SHIFT+1) cycles.
- After a switch, the first `clk_sel_out` high occurs 2^(new+BASE_SHIFT) cycles after the boundary edge. `sample_stb_out` fires in that same cycle.
- Selected-clock pulses are never shorter than the half-period of either rate involved in the switch.

## Configuration
- Macro `ADC_FREQ_SEL_SYNC_EN`:
  - Defined: `sel_in` passes through a 2-flop synchronizer before `sel_tgt`. Use this when `sel_in` comes from switches or another domain.
  - Undefined: `sel_in` is registered directly into `sel_tgt`, and `sel_in` must be synchronous to `clk_in`.
- All other behaviour is identical in both configurations.

## Structure
- Shared package `adc_freq_pkg` holds:
  - `ADC_FREQ_NUM` = 8.
  - `ADC_FREQ_SEL_W` = 3.
  - The rate-index typedef.
  - The function that computes the boundary mask from (m, `BASE_SHIFT`).
- One sub-module, `adc_sel_sync`: a 2-flop synchronizer, 3 bits wide, with synchronous active-low reset. It is instantiated only under `ADC_FREQ_SEL_SYNC_EN`.

## Test plan
All scenarios use the default `BASE_SHIFT`=2 with the synchronizer disabled unless noted.
- Reset release with `sel_in`=0:
  - `clk_div_out[0]` toggles every 4 cycles.
  - `clk_div_out[7]` toggles every 512 cycles.
  - `clk_sel_out` equals `clk_div_out[0]`.
  - `sample_stb_out` pulses every 8 cycles, in the cycle `clk_sel_out` first goes high.
- Switch 0 to 7, with `sel_in`=7 applied at `cnt`=5:
  - `sel_busy_out` is high from `cnt`=6 through `cnt`=1023.
  - `sel_act` becomes 7 at the wrap to 0.
  - The first `clk_sel_out` high is at `cnt`=512.
  - `clk_sel_out` never goes high between the switch and that point.
- Switch 7 to 2 in mid-period (`cnt`=300):
  - The switch is applied at the next wrap of `cnt[9:0]`.
  - After the switch, `clk_sel_out` has a period of 32 cycles.
  - No high pulse shorter than 16 cycles appears.
- Retarget while busy (0 to 5, then 3 before the boundary):
  - `sel_act` goes directly to 3 at the `cnt[5:0]` all-ones boundary.
  - Index 5 is never active.
- Synchronous reset asserted mid-switch:
  - On the next edge all outputs are 0 and `cnt`=0.
  - After release the block runs at index 0.
  - An asynchronous pulse on `rst_n_in` between edges has no effect.
- `ADC_FREQ_SEL_SYNC_EN` defined:
  - A `sel_in` change reaches `sel_busy_out` 3 cycles later.
  - Otherwise results match the switch 0-to-7 scenario, shifted by 2 cycles.
